// File: rtl/dsp_pkg.sv
// Shared constants and elaboration-time helpers for the DSP result collector.
package dsp_pkg;

  localparam int PWIDTH_DEFAULT = 48;
  localparam int DEPTH_DEFAULT  = 4;

  // Total register stages between operand acceptance and a valid P output.
  function automatic int dsp_latency(input int abreg, input int mreg, input int preg);
    return abreg + mreg + preg;
  endfunction

  // Ceiling log2 for sizing pointers and counters (clog2(1) = 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/dsp_result_fifo.sv
// Synchronous result FIFO: registered occupancy, power-of-two depth,
// head word forced to zero while empty so the output is clean after reset.
module dsp_result_fifo
  import dsp_pkg::*;
#(
  parameter  int WIDTH = 49,
  parameter  int DEPTH = 4,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [AW:0]      o_level,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_level == FULL_LEVEL);
  assign o_empty = (r_level == '0);
  assign w_wr    = i_wr_en && !o_full;
  assign w_rd    = i_rd_en && !o_empty;

  // Storage array: written on every accepted push.
  // NOTE: the data array has no reset; pointers and level define validity and the head is masked while empty.
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // Upstream flow control must make overflow and underflow impossible.
  a_no_overflow:  assert property (@(posedge i_clk) disable iff (i_rst) !(i_wr_en && o_full));
  a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst) !(i_rd_en && o_empty));

endmodule

// File: rtl/dsp_result_collector.sv
// Tracks operand-valid tokens through the DSP48A1 register stages, captures
// {CARRYOUT, P} when a token emerges, and freezes the DSP via ce_out when the
// result FIFO is full so that no result is lost.
module dsp_result_collector
  import dsp_pkg::*;
#(
  parameter  int ABREG  = 2,
  parameter  int MREG   = 1,
  parameter  int PREG   = 1,
  parameter  int PWIDTH = PWIDTH_DEFAULT,
  parameter  int DEPTH  = DEPTH_DEFAULT,
  localparam int LW     = clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ce_out,
  input  logic [PWIDTH-1:0] P_in,
  input  logic              CARRYOUT_in,
  output logic [PWIDTH:0]   out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LW-1:0]     level
);

  localparam int LAT = dsp_latency(ABREG, MREG, PREG);

  logic w_ce;
  logic w_tail;
  logic w_full;
  logic w_empty;
  logic w_wr_en;
  logic w_rd_en;

  // Enable is held high during reset so the DSP registers see their own reset;
  // otherwise it depends only on the registered FIFO count.
  assign w_ce     = rst || !w_full;
  assign ce_out   = w_ce;
  assign in_ready = w_ce;

  generate
    if (LAT == 0) begin : g_no_tok
      assign w_tail = in_valid;
    end else begin : g_tok
      logic [LAT-1:0] r_tok;

      // Token line mirrors the DSP pipeline: it shifts only when the DSP registers are enabled.
      // NOTE: non-blocking assignments let every stage read its neighbour's pre-edge value.
      always_ff @(posedge CLK) begin
        if (rst) begin
          r_tok <= '0;
        end else if (w_ce) begin
          r_tok[0] <= in_valid;
          for (int i = 1; i < LAT; i++) begin
            r_tok[i] <= r_tok[i-1];
          end
        end
      end

      assign w_tail = r_tok[LAT-1];
    end
  endgenerate

  assign w_wr_en = w_ce && w_tail;
  assign w_rd_en = !w_empty && out_ready;

  dsp_result_fifo #(
    .WIDTH (PWIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (CLK),
    .i_rst     (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_data ({CARRYOUT_in, P_in}),
    .i_rd_en   (w_rd_en),
    .o_rd_data (out_data),
    .o_level   (level),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign out_valid = !w_empty;

endmodule

// File: tb/tb_dsp_result_collector.sv
// Directed bench: DUT A uses default stages (LAT=4), DUT B has no stages (LAT=0).
// A small behavioural DSP pipeline feeds P/CARRYOUT to DUT A, gated by its ce_out.
module tb_dsp_result_collector;

  localparam int PW = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          iv_a, ir_a, ce_a, ord_a, ov_a, cy_a, cyp_a;
  logic [PW-1:0] op_a, p_a;
  logic [PW:0]   od_a;
  logic [2:0]    lvl_a;

  logic          iv_b, ir_b, ce_b, ord_b, ov_b, cy_b;
  logic [PW-1:0] op_b;
  logic [PW:0]   od_b;
  logic [2:0]    lvl_b;

  logic [PW-1:0] pp_a [4];
  logic [3:0]    cp_a;

  int n_checks = 0;
  int n_fail   = 0;

  int src_n, src_base, src_idx;

  // Behavioural four-stage DSP pipeline for DUT A, frozen whenever ce is low.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) pp_a[i] <= '0;
      cp_a <= '0;
    end else if (ce_a) begin
      pp_a[0] <= op_a;
      for (int i = 1; i < 4; i++) pp_a[i] <= pp_a[i-1];
      cp_a <= {cp_a[2:0], cy_a};
    end
  end
  assign p_a   = pp_a[3];
  assign cyp_a = cp_a[3];

  dsp_result_collector u_dut_a (
    .CLK         (clk),
    .rst         (rst),
    .in_valid    (iv_a),
    .in_ready    (ir_a),
    .ce_out      (ce_a),
    .P_in        (p_a),
    .CARRYOUT_in (cyp_a),
    .out_data    (od_a),
    .out_valid   (ov_a),
    .out_ready   (ord_a),
    .level       (lvl_a)
  );

  dsp_result_collector #(.ABREG(0), .MREG(0), .PREG(0)) u_dut_b (
    .CLK         (clk),
    .rst         (rst),
    .in_valid    (iv_b),
    .in_ready    (ir_b),
    .ce_out      (ce_b),
    .P_in        (op_b),
    .CARRYOUT_in (cy_b),
    .out_data    (od_b),
    .out_valid   (ov_b),
    .out_ready   (ord_b),
    .level       (lvl_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected FIFO word for the k-th token of a stream: P = base+k, CARRYOUT = k[0].
  function automatic logic [63:0] exp_word(input int base, input int k);
    logic [63:0] e;
    e     = 64'(base + k);
    e[PW] = k[0];
    return e;
  endfunction

  // One source cycle on DUT A: offer the next token, hold it until accepted.
  task automatic src_cycle();
    logic acc;
    iv_a = (src_idx < src_n);
    op_a = PW'(src_base + src_idx);
    cy_a = src_idx[0];
    acc  = iv_a && ir_a;
    tick();
    if (acc) src_idx++;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    iv_a  = 1'b0;
    iv_b  = 1'b0;
    ord_a = 1'b0;
    ord_b = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Stream n tokens into a stalled consumer until full, hold, then drain and check order.
  task automatic stream_drain(input string name, input int n, input int base, input int hold);
    int got;
    int budget;
    ord_a    = 1'b0;
    src_n    = n;
    src_base = base;
    src_idx  = 0;
    budget   = 0;
    while (lvl_a != 3'd4 && budget < 40) begin
      src_cycle();
      budget++;
    end
    check({name, "_full_level"}, lvl_a, 4);
    check({name, "_ce_low"}, ce_a, 0);
    check({name, "_ready_low"}, ir_a, 0);
    for (int i = 0; i < hold; i++) src_cycle();
    check({name, "_hold_level"}, lvl_a, 4);
    ord_a  = 1'b1;
    got    = 0;
    budget = 0;
    while (got < n && budget < 80) begin
      if (ov_a) begin
        check({name, "_data"}, od_a, exp_word(base, got));
        got++;
      end
      src_cycle();
      budget++;
    end
    check({name, "_count"}, got, n);
    for (int i = 0; i < 6; i++) src_cycle();
    check({name, "_no_extra"}, ov_a, 0);
    check({name, "_level_end"}, lvl_a, 0);
  endtask

  initial begin
    int budget;
    rst   = 1'b1;
    iv_a  = 1'b0; op_a = '0; cy_a = 1'b0; ord_a = 1'b0;
    iv_b  = 1'b0; op_b = '0; cy_b = 1'b0; ord_b = 1'b0;
    src_n = 0; src_base = 0; src_idx = 0;

    // Reset state, sampled while reset is still asserted.
    tick();
    tick();
    check("rst_a_valid", ov_a, 0);
    check("rst_a_level", lvl_a, 0);
    check("rst_a_data", od_a, 0);
    check("rst_a_ce", ce_a, 1);
    check("rst_b_valid", ov_b, 0);
    check("rst_b_level", lvl_b, 0);
    check("rst_b_data", od_b, 0);
    rst = 1'b0;
    tick();
    check("post_rst_ce", ce_a, 1);
    check("post_rst_ready", ir_a, 1);

    // Latency with four stages: result valid exactly 5 cycles after acceptance.
    ord_a = 1'b1;
    iv_a  = 1'b1;
    op_a  = 48'h0000_0000_0123;
    cy_a  = 1'b0;
    check("lat4_valid_0", ov_a, 0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      iv_a = 1'b0;
      check("lat4_valid", ov_a, (i == 5));
      if (i == 5) check("lat4_data", od_a, {1'b0, 48'h123});
    end

    // Latency with no stages: result valid one cycle after acceptance.
    ord_b = 1'b1;
    iv_b  = 1'b1;
    op_b  = 48'h0000_0000_0123;
    cy_b  = 1'b0;
    check("lat0_valid_0", ov_b, 0);
    for (int i = 1; i <= 2; i++) begin
      tick();
      iv_b = 1'b0;
      check("lat0_valid", ov_b, (i == 1));
      if (i == 1) check("lat0_data", od_b, {1'b0, 48'h123});
    end

    // Backpressure: 8 tokens with P=1..8, FIFO fills and the DSP freezes.
    do_reset();
    stream_drain("bp", 8, 1, 4);

    // Freeze with exactly 3 tokens in flight when the FIFO fills.
    do_reset();
    stream_drain("freeze", 7, 32'h11, 5);

    // Source keeps in_valid high while not ready; held tokens must not be captured twice.
    do_reset();
    stream_drain("held_src", 12, 32'h40, 3);

    // Simultaneous write and read at level DEPTH-1.
    do_reset();
    ord_a    = 1'b0;
    src_n    = 1000;
    src_base = 32'h60;
    src_idx  = 0;
    budget   = 0;
    while (lvl_a != 3'd3 && budget < 20) begin
      src_cycle();
      budget++;
    end
    check("simul_pre_level", lvl_a, 3);
    ord_a = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("simul_head", od_a, exp_word(32'h60, j));
      src_cycle();
      check("simul_level", lvl_a, 3);
      check("simul_ce", ce_a, 1);
    end

    // Mid-stream reset with level 3 and 2 tokens in flight.
    do_reset();
    ord_a    = 1'b0;
    src_n    = 5;
    src_base = 32'h70;
    src_idx  = 0;
    budget   = 0;
    while (lvl_a != 3'd3 && budget < 20) begin
      src_cycle();
      budget++;
    end
    check("mid_pre_level", lvl_a, 3);
    check("mid_pre_accepted", src_idx, 5);
    rst  = 1'b1;
    iv_a = 1'b0;
    tick();
    rst = 1'b0;
    check("mid_level", lvl_a, 0);
    check("mid_valid", ov_a, 0);
    check("mid_data", od_a, 0);
    check("mid_ce", ce_a, 1);
    ord_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      src_cycle();
      check("mid_no_stale", ov_a, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
